// File: rtl/frame_ram_ctrl.sv
// rtl/frame_ram_ctrl.sv - frame RAM writer/reader with min/max stats and 2-entry output FIFO
module frame_ram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int RAM_DEPTH  = 76800,
    parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                  clk_i_ctrl,
    input  logic                  rst_i_ctrl,
    input  logic                  start_i,
    input  logic                  pix_valid_i,
    input  logic [DATA_WIDTH-1:0] pix_data_i,
    output logic                  pix_ready_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] min_o,
    output logic [DATA_WIDTH-1:0] max_o,
    output logic                  stats_valid_o,
    output logic                  en_o_ram,
    output logic                  we_o_ram,
    output logic                  re_o_ram,
    output logic [ADDR_WIDTH-1:0] address_o_ram,
    output logic [DATA_WIDTH-1:0] data_o_ram,
    input  logic [DATA_WIDTH-1:0] data_i_ram,
    input  logic                  write2ram_done_i,
    input  logic                  read_from_ram_done_i,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic                  err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WR_CHECK,
        S_READ,
        S_DRAIN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] out_idx;
    logic                  drain_first;

    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  fifo_wr_ptr;
    logic                  fifo_rd_ptr;
    logic [1:0]            fifo_count;
    logic                  inflight;

    logic                  wr_fire;
    logic                  rd_issue;
    logic                  pop;
    logic [2:0]            credit_used;

    // Handshakes, read credit and RAM drive; everything gated off while reset is asserted
    always_comb begin
        busy_o        = (state != S_IDLE);
        pix_ready_o   = (state == S_WRITE) && !rst_i_ctrl;
        out_valid_o   = (fifo_count != 2'd0);
        out_data_o    = fifo_mem[fifo_rd_ptr];
        out_last_o    = out_valid_o && (out_idx == LAST_ADDR);
        wr_fire       = pix_ready_o && pix_valid_i;
        pop           = out_valid_o && out_ready_i;
        credit_used   = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
        rd_issue      = (state == S_READ) && !rst_i_ctrl && (credit_used < 3'd2);
        en_o_ram      = wr_fire || rd_issue;
        we_o_ram      = wr_fire;
        re_o_ram      = rd_issue;
        address_o_ram = wr_fire ? wr_addr : (rd_issue ? rd_addr : '0);
        data_o_ram    = wr_fire ? pix_data_i : '0;
    end

    // Frame sequencing, statistics and done-flag checking
    always_ff @(posedge clk_i_ctrl) begin
        if (rst_i_ctrl) begin
            state         <= S_IDLE;
            wr_addr       <= '0;
            rd_addr       <= '0;
            drain_first   <= 1'b0;
            min_o         <= '0;
            max_o         <= '0;
            stats_valid_o <= 1'b0;
            frame_done_o  <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        wr_addr       <= '0;
                        min_o         <= '1;
                        max_o         <= '0;
                        stats_valid_o <= 1'b0;
                        state         <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (wr_fire) begin
                        if (pix_data_i < min_o) min_o <= pix_data_i;
                        if (pix_data_i > max_o) max_o <= pix_data_i;
                        if (wr_addr == LAST_ADDR) state <= S_WR_CHECK;
                        else                      wr_addr <= wr_addr + ADDR_ONE;
                    end
                end
                S_WR_CHECK: begin
                    if (!write2ram_done_i) err_o <= 1'b1;
                    stats_valid_o <= 1'b1;
                    rd_addr       <= '0;
                    state         <= S_READ;
                end
                S_READ: begin
                    if (rd_issue) begin
                        if (rd_addr == LAST_ADDR) begin
                            drain_first <= 1'b1;
                            state       <= S_DRAIN;
                        end else begin
                            rd_addr <= rd_addr + ADDR_ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    drain_first <= 1'b0;
                    if (drain_first && !read_from_ram_done_i) err_o <= 1'b1;
                    // The last pixel is the only one left, so its pop empties the pipe
                    if (pop && out_last_o) begin
                        frame_done_o <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output FIFO: capture read data one cycle after issue, track popped pixel index
    always_ff @(posedge clk_i_ctrl) begin
        if (rst_i_ctrl) begin
            for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_count  <= 2'd0;
            inflight    <= 1'b0;
            out_idx     <= '0;
        end else begin
            inflight <= rd_issue;
            if (inflight) begin
                fifo_mem[fifo_wr_ptr] <= data_i_ram;
                fifo_wr_ptr           <= ~fifo_wr_ptr;
            end
            if (pop) fifo_rd_ptr <= ~fifo_rd_ptr;
            fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
            if (state == S_WR_CHECK) out_idx <= '0;
            else if (pop)            out_idx <= out_idx + ADDR_ONE;
        end
    end

endmodule
